// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor
// Brief    : Receive-side checker for red/yellow/green lamp lines. Registers
//            the lamp code, tracks the phase with a small FSM, measures the
//            dwell of each phase and raises sticky error flags for illegal
//            codes, out-of-order phase changes and phases held too briefly.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
  parameter int RED_MIN    = 6,
  parameter int GREEN_MIN  = 32,
  parameter int YELLOW_MIN = 8,
  parameter int CNT_W      = 8,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clear_err,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] last_dwell,
  output logic             cycle_done,
  output logic             err_illegal,
  output logic             err_seq,
  output logic             err_short,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_RED     = 2'd1,
    ST_GREEN   = 2'd2,
    ST_YELLOW  = 2'd3
  } state_t;

  // Minimums are clamped to the counter range; a saturated dwell always passes.
  localparam int MAX_CNT = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] RED_MIN_C    = CNT_W'((RED_MIN    > MAX_CNT) ? MAX_CNT : RED_MIN);
  localparam logic [CNT_W-1:0] GREEN_MIN_C  = CNT_W'((GREEN_MIN  > MAX_CNT) ? MAX_CNT : GREEN_MIN);
  localparam logic [CNT_W-1:0] YELLOW_MIN_C = CNT_W'((YELLOW_MIN > MAX_CNT) ? MAX_CNT : YELLOW_MIN);
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, next_state;
  logic [2:0]       sample;
  logic             measured, next_measured;
  logic [CNT_W-1:0] next_dwell, next_last;
  logic             next_cycle_done;
  logic             ev_illegal, ev_seq, ev_short;

  logic             code_valid;
  state_t           code_state;
  logic [CNT_W-1:0] cur_min;
  logic             dwell_sat;
  logic             legal_step;

  logic [1:0]       n_events;
  logic [ERR_W-1:0] err_base;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] next_err_count;

  assign phase     = state;
  assign dwell_sat = (dwell == {CNT_W{1'b1}});

  // Lamp sample register: {red, yellow, green}.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample <= 3'b000;
    end else begin
      sample <= {red, yellow, green};
    end
  end

  // Decode the sampled lamp code into a phase; anything not one-hot is illegal.
  always_comb begin
    code_valid = 1'b1;
    code_state = ST_UNKNOWN;
    case (sample)
      3'b100:  code_state = ST_RED;
      3'b001:  code_state = ST_GREEN;
      3'b010:  code_state = ST_YELLOW;
      default: code_valid = 1'b0;
    endcase
  end

  // Minimum dwell and legal successor for the phase currently held.
  always_comb begin
    cur_min    = {CNT_W{1'b0}};
    legal_step = 1'b0;
    case (state)
      ST_RED: begin
        cur_min    = RED_MIN_C;
        legal_step = (code_state == ST_GREEN);
      end
      ST_GREEN: begin
        cur_min    = GREEN_MIN_C;
        legal_step = (code_state == ST_YELLOW);
      end
      ST_YELLOW: begin
        cur_min    = YELLOW_MIN_C;
        legal_step = (code_state == ST_RED);
      end
      default: begin
        cur_min    = {CNT_W{1'b0}};
        legal_step = 1'b0;
      end
    endcase
  end

  // Phase FSM: next state, dwell bookkeeping and error events for this cycle.
  always_comb begin
    next_state      = state;
    next_dwell      = dwell;
    next_last       = last_dwell;
    next_measured   = measured;
    next_cycle_done = 1'b0;
    ev_illegal      = 1'b0;
    ev_seq          = 1'b0;
    ev_short        = 1'b0;

    if (state == ST_UNKNOWN) begin
      // Still hunting for a phase: partial first phases are never min-checked.
      if (code_valid) begin
        next_state    = code_state;
        next_dwell    = CNT_ONE;
        next_measured = 1'b0;
      end else begin
        next_dwell = {CNT_W{1'b0}};
      end
    end else if (!code_valid) begin
      next_state = ST_UNKNOWN;
      next_dwell = {CNT_W{1'b0}};
      ev_illegal = 1'b1;
    end else if (code_state == state) begin
      next_dwell = dwell_sat ? dwell : dwell + CNT_ONE;
    end else begin
      next_last  = dwell;
      ev_short   = measured && !dwell_sat && (dwell < cur_min);
      next_state = code_state;
      next_dwell = CNT_ONE;
      if (legal_step) begin
        next_measured   = 1'b1;
        next_cycle_done = (state == ST_YELLOW);
      end else begin
        // Resynchronise to the new phase, but its length is not trusted.
        next_measured = 1'b0;
        ev_seq        = 1'b1;
      end
    end
  end

  // Error counter: a same-cycle clear drops history but keeps new events.
  always_comb begin
    n_events = {1'b0, ev_illegal} + {1'b0, ev_seq} + {1'b0, ev_short};
    err_base = clear_err ? {ERR_W{1'b0}} : err_count;
    err_sum  = {1'b0, err_base} + (ERR_W+1)'(n_events);
    next_err_count = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  end

  // State, dwell and pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_UNKNOWN;
      dwell      <= {CNT_W{1'b0}};
      last_dwell <= {CNT_W{1'b0}};
      measured   <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state      <= next_state;
      dwell      <= next_dwell;
      last_dwell <= next_last;
      measured   <= next_measured;
      cycle_done <= next_cycle_done;
    end
  end

  // Sticky error flags and saturating event counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_short   <= 1'b0;
      err_count   <= {ERR_W{1'b0}};
    end else begin
      err_illegal <= (err_illegal && !clear_err) || ev_illegal;
      err_seq     <= (err_seq     && !clear_err) || ev_seq;
      err_short   <= (err_short   && !clear_err) || ev_short;
      err_count   <= next_err_count;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_monitor
// Brief    : Table-driven self-checking bench for traffic_light_monitor.
//            Each record holds a lamp code held for n cycles and the outputs
//            expected afterwards; reset behaviour is exercised by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

  logic       clk;
  logic       reset_n;
  logic       red, yellow, green;
  logic       clear_err;
  logic [1:0] phase;
  logic [7:0] dwell, last_dwell;
  logic       cycle_done;
  logic       err_illegal, err_seq, err_short;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  traffic_light_monitor #(
    .RED_MIN(6), .GREEN_MIN(32), .YELLOW_MIN(8), .CNT_W(8), .ERR_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .red(red), .yellow(yellow), .green(green),
    .clear_err(clear_err),
    .phase(phase), .dwell(dwell), .last_dwell(last_dwell),
    .cycle_done(cycle_done),
    .err_illegal(err_illegal), .err_seq(err_seq), .err_short(err_short),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [1:0] PU = 2'd0, PR = 2'd1, PG = 2'd2, PY = 2'd3;

  typedef struct {
    logic [2:0] lamps;   // {red, yellow, green}
    logic       clr;
    int         n;
    logic [1:0] ph;
    logic [7:0] dw;
    logic [7:0] last;
    logic       cd;
    logic [2:0] flags;   // {illegal, seq, short}
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  task automatic add(input logic [2:0] lamps, input logic clr, input int n,
                     input logic [1:0] ph, input logic [7:0] dw, input logic [7:0] last,
                     input logic cd, input logic [2:0] flags, input logic [7:0] cnt);
    vecs[nvec].lamps = lamps; vecs[nvec].clr = clr; vecs[nvec].n = n;
    vecs[nvec].ph = ph; vecs[nvec].dw = dw; vecs[nvec].last = last;
    vecs[nvec].cd = cd; vecs[nvec].flags = flags; vecs[nvec].cnt = cnt;
    nvec++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] ph, input logic [7:0] dw,
                           input logic [7:0] last, input logic cd, input logic [2:0] flags,
                           input logic [7:0] cnt);
    chk({tag, ".phase"},      int'(phase),      int'(ph));
    chk({tag, ".dwell"},      int'(dwell),      int'(dw));
    chk({tag, ".last_dwell"}, int'(last_dwell), int'(last));
    chk({tag, ".cycle_done"}, int'(cycle_done), int'(cd));
    chk({tag, ".err_flags"},  int'({err_illegal, err_seq, err_short}), int'(flags));
    chk({tag, ".err_count"},  int'(err_count),  int'(cnt));
  endtask

  // Inputs change on the falling edge; outputs are read on the falling edge.
  task automatic apply(input int idx);
    for (int k = 0; k < vecs[idx].n; k++) begin
      {red, yellow, green} = vecs[idx].lamps;
      clear_err = vecs[idx].clr;
      @(posedge clk);
      @(negedge clk);
    end
    clear_err = 1'b0;
    check_all($sformatf("v%0d", idx), vecs[idx].ph, vecs[idx].dw, vecs[idx].last,
              vecs[idx].cd, vecs[idx].flags, vecs[idx].cnt);
  endtask

  int split;

  initial begin
    reset_n = 1'b0; clear_err = 1'b0;
    {red, yellow, green} = 3'b000;

    // Legal loop R6 G32 Y8 then red: cycle_done one pulse, two edges after red.
    add(R, 0,  6, PR,  5,  0, 0, 3'b000, 0);
    add(G, 0, 32, PG, 31,  6, 0, 3'b000, 0);
    add(Y, 0,  8, PY,  7, 32, 0, 3'b000, 0);
    add(R, 0,  1, PY,  8, 32, 0, 3'b000, 0);
    add(R, 0,  1, PR,  1,  8, 1, 3'b000, 0);
    add(R, 0,  1, PR,  2,  8, 0, 3'b000, 0);
    add(R, 0,  3, PR,  5,  8, 0, 3'b000, 0);
    // Short green (20 < 32).
    add(G, 0, 20, PG, 19,  6, 0, 3'b000, 0);
    add(Y, 0,  2, PY,  1, 20, 0, 3'b001, 1);
    add(Y, 0,  7, PY,  8, 20, 0, 3'b001, 1);
    // RED -> YELLOW sequence error, then short unmeasured yellow.
    add(R, 0,  6, PR,  5,  9, 0, 3'b001, 1);
    add(Y, 0,  2, PY,  1,  6, 0, 3'b011, 2);
    add(R, 0,  2, PR,  1,  2, 1, 3'b011, 2);
    add(R, 0,  4, PR,  5,  2, 0, 3'b011, 2);
    // Illegal code red+green during green.
    add(G, 0, 10, PG,  9,  6, 0, 3'b011, 2);
    add(3'b101, 0, 1, PG, 10, 6, 0, 3'b011, 2);
    add(G, 0,  1, PU,  0,  6, 0, 3'b111, 3);
    add(G, 0,  1, PG,  1,  6, 0, 3'b111, 3);
    add(Y, 0,  2, PY,  1,  2, 0, 3'b111, 3);
    // Clear coinciding with a sequence error, then clear alone.
    add(Y, 0,  7, PY,  8,  2, 0, 3'b111, 3);
    add(G, 0,  1, PY,  9,  2, 0, 3'b111, 3);
    add(G, 1,  1, PG,  1,  9, 0, 3'b010, 1);
    add(G, 1,  1, PG,  2,  9, 0, 3'b000, 0);
    add(G, 0,  1, PG,  3,  9, 0, 3'b000, 0);
    // Short and sequence error in one cycle count twice.
    add(Y, 0,  2, PY,  1,  4, 0, 3'b000, 0);
    add(Y, 0,  0, PY,  1,  4, 0, 3'b000, 0);
    add(G, 0,  2, PG,  1,  2, 0, 3'b011, 2);
    add(G, 0, 14, PG, 15,  2, 0, 3'b011, 2);
    split = nvec;
    // After a mid-green reset: unmeasured 3-cycle green, then red saturation.
    add(G, 0,   3, PG,   2,   0, 0, 3'b000, 0);
    add(Y, 0,   2, PY,   1,   3, 0, 3'b000, 0);
    add(Y, 0,   7, PY,   8,   3, 0, 3'b000, 0);
    add(R, 0, 300, PR, 255,   9, 0, 3'b000, 0);
    add(G, 0,   2, PG,   1, 255, 0, 3'b000, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", PU, 0, 0, 0, 3'b000, 0);
    reset_n = 1'b1;

    for (int i = 0; i < split; i++) apply(i);

    // Asynchronous reset mid-green at dwell 15: outputs clear without a clock edge.
    #1 reset_n = 1'b0;
    {red, yellow, green} = 3'b000;
    #1 check_all("async_rst", PU, 0, 0, 0, 3'b000, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = split; i < nvec; i++) apply(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Receive-side checker for the red/yellow/green lamp outputs of a traffic light controller.
- Samples the three lamp lines on the controller's clock and decodes the current phase.
- Measures how long each phase is held, and flags illegal lamp codes, out-of-order phase changes and phases shorter than their minimum.
- Used in the light-controller subsystem for run-time supervision and as a bench checker.

Parameters:
- RED_MIN, 6, minimum legal red dwell in clock cycles.
- GREEN_MIN, 32, minimum legal green dwell in clock cycles.
- YELLOW_MIN, 8, minimum legal yellow dwell in clock cycles.
- CNT_W, 8, width of the dwell counters. Saturating.
- ERR_W, 8, width of the error event counter. Saturating.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- red  input  1  red lamp line from the controller.
- yellow  input  1  yellow lamp line.
- green  input  1  green lamp line.
- clear_err  input  1  synchronous clear of the sticky error flags and err_count.
- phase  output  2  decoded phase: 0 = UNKNOWN, 1 = RED, 2 = GREEN, 3 = YELLOW.
- dwell  output  CNT_W  cycles the current lamp code has been held.
- last_dwell  output  CNT_W  final dwell of the most recently completed phase.
- cycle_done  output  1  one-cycle pulse on a legal YELLOW->RED transition.
- err_illegal  output  1  sticky: a lamp code was not one-hot.
- err_seq  output  1  sticky: a phase change violated RED->GREEN->YELLOW->RED.
- err_short  output  1  sticky: a measured phase ended below its minimum.
- err_count  output  ERR_W  total error events, saturating.

Behaviour:
- Reset (async assert, sync release):
  - phase = UNKNOWN; dwell = 0; last_dwell = 0; cycle_done = 0.
  - All err_* flags = 0; err_count = 0.
  - Sample register = 3'b000; measured flag = 0.
- Sampling: {red, yellow, green} registered every clk into the sample register. The FSM acts on the sample. Latency: an input change before edge k is reflected on phase/flags after edge k+1.
- Code decode: 100 = RED, 001 = GREEN, 010 = YELLOW (order red, yellow, green). Any other code (000, or more than one lamp lit) is illegal.
- FSM states: UNKNOWN, RED, GREEN, YELLOW.
- UNKNOWN:
  - Valid code -> enter that phase; dwell = 1; measured = 0 (partial phase, not min-checked).
  - Illegal code -> stay in UNKNOWN; dwell = 0. No error is raised while still in UNKNOWN.
- In a phase, same code as the current phase: dwell increments each cycle, saturating at all-ones.
- In a phase, different valid code:
  - last_dwell <= dwell.
  - If measured = 1 and dwell < MIN of the phase being left: raise err_short.
  - If the transition is legal (RED->GREEN, GREEN->YELLOW, YELLOW->RED): enter the new phase; measured = 1; dwell = 1. On YELLOW->RED, pulse cycle_done.
  - If the transition is illegal: raise err_seq; enter the new phase anyway (resync); measured = 0; dwell = 1.
- In a phase, illegal code: raise err_illegal; phase -> UNKNOWN; dwell = 0; last_dwell unchanged; no err_short check.
- A dwell value that has saturated compares as >= any MIN.
- Error events:
  - err_count increments by the number of events raised in that cycle (err_short and err_seq can coincide, giving +2). Saturates at all-ones.
  - Flags are sticky until clear_err.
- clear_err: next edge clears the flags and err_count. If an error is raised in the same cycle, the new event wins: the flag is set and err_count = number of new events.
- Reset mid-phase: everything returns to reset values immediately. The first phase after reset is unmeasured.

Test Plan:
1. Legal loop: drive red 6, green 32, yellow 8 cycles, then red again -> sequence RED, GREEN, YELLOW, RED; no error flags; last_dwell = 32 after GREEN->YELLOW; cycle_done pulses exactly once, 2 edges after red reasserts.
2. Short phase: after a full red, hold green 20 cycles, then yellow -> err_short = 1; err_count = 1; last_dwell = 20; phase = YELLOW.
3. Sequence error: RED (6) then directly YELLOW -> err_seq = 1; err_count = 1; phase = YELLOW; a following short YELLOW->RED does not raise err_short (unmeasured).
4. Illegal code: during GREEN drive red = green = 1 for 1 cycle, then green -> err_illegal = 1; phase goes UNKNOWN then GREEN; dwell restarts at 1; no err_short.
5. Clear vs new error: assert clear_err in the same cycle an err_seq is raised -> err_seq = 1, err_count = 1, other flags = 0. clear_err alone on a later cycle -> all flags 0, err_count 0.
6. Async reset mid-GREEN at dwell = 15 -> all outputs at reset values immediately. After release, the first green is unmeasured; a 3-cycle first phase gives no err_short. Dwell saturation: hold red 300 cycles with CNT_W = 8 -> dwell = 255.
